// File: rtl/mac_pkg.sv
// Shared types, constants and the byte-wide CRC-32 step for the MAC transmit path.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  // Register is kept MSB-first; each data byte enters LSB first (reflected input).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_tx_crc32.sv
// CRC-32 accumulator for the transmit FCS; presents the next FCS byte on fcs_byte
// and shifts it out one byte per shift strobe.
module mac_tx_crc32
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       en,
  input  logic       shift,
  input  logic [7:0] data,
  output logic [7:0] fcs_byte
);

  logic [31:0] crc;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset sits in the sensitivity list to act without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      crc <= CRC_INIT;
    else if (init)  crc <= CRC_INIT;
    else if (en)    crc <= crc32_byte(crc, data);
    else if (shift) crc <= {crc[23:0], 8'hFF};
  end

  // FCS bit i is the complement of register bit 31-i, so the top byte leaves first.
  assign fcs_byte = ~{crc[24], crc[25], crc[26], crc[27],
                      crc[28], crc[29], crc[30], crc[31]};

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer: preamble/SFD, optional short-frame padding, FCS, IFG.
// Build option: define MAC_TX_PAD_EN to pad frames to MIN_FRAME bytes before the FCS.
module mac_tx_framer
  import mac_pkg::*;
#(
`ifdef MAC_TX_PAD_EN
  parameter int MIN_FRAME    = 60,
  parameter int CNT_W        = 11,
`endif
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       underrun,
  output logic       busy
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int IFG_W = $clog2(IFG_BYTES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_BYTES - 1);

  state_t           state;
  logic [PRE_W-1:0] pre_cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic [1:0]       fcs_cnt;

  logic       crc_init;
  logic       crc_en;
  logic       crc_shift;
  logic [7:0] crc_data;
  logic [7:0] fcs_byte;

`ifdef MAC_TX_PAD_EN
  localparam logic [CNT_W:0] MIN_LEN = (CNT_W + 1)'(MIN_FRAME);

  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W:0]   cnt_inc;

  // cnt_inc is the unsaturated count including the byte sent this cycle.
  assign cnt_inc = {1'b0, byte_cnt} + (CNT_W + 1)'(1);
  assign cnt_sat = (&byte_cnt) ? byte_cnt : byte_cnt + CNT_W'(1);
`endif

  assign in_ready  = (state == DATA);
  assign crc_init  = (state == SFD);
  assign crc_en    = ((state == DATA) && in_valid) || (state == PAD);
  assign crc_shift = (state == FCS);
  assign crc_data  = (state == DATA) ? in_data : 8'h00;

  mac_tx_crc32 u_crc (
    .clk      (clk),
    .reset    (reset),
    .init     (crc_init),
    .en       (crc_en),
    .shift    (crc_shift),
    .data     (crc_data),
    .fcs_byte (fcs_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      ifg_cnt  <= '0;
      fcs_cnt  <= '0;
      txd      <= 8'h00;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
`ifdef MAC_TX_PAD_EN
      byte_cnt <= '0;
`endif
    end else begin
      tx_er    <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          tx_en <= 1'b0;
          txd   <= 8'h00;
          if (in_valid) begin
            state   <= PRE;
            pre_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        PRE: begin
          tx_en <= 1'b1;
          txd   <= PREAMBLE_BYTE;
          if (pre_cnt == PRE_LAST) state <= SFD;
          else                     pre_cnt <= pre_cnt + PRE_W'(1);
        end
        SFD: begin
          tx_en   <= 1'b1;
          txd     <= SFD_BYTE;
          fcs_cnt <= '0;
`ifdef MAC_TX_PAD_EN
          byte_cnt <= '0;
`endif
          state   <= DATA;
        end
        DATA: begin
          tx_en <= 1'b1;
          if (in_valid) begin
            txd <= in_data;
`ifdef MAC_TX_PAD_EN
            byte_cnt <= cnt_sat;
            if (in_last) state <= (cnt_inc < MIN_LEN) ? PAD : FCS;
`else
            if (in_last) state <= FCS;
`endif
          end else begin
            // Upstream starved mid-frame: poison the frame and skip the FCS.
            txd      <= 8'h00;
            tx_er    <= 1'b1;
            underrun <= 1'b1;
            ifg_cnt  <= '0;
            state    <= IFG;
          end
        end
`ifdef MAC_TX_PAD_EN
        PAD: begin
          tx_en    <= 1'b1;
          txd      <= 8'h00;
          byte_cnt <= cnt_sat;
          if (cnt_inc >= MIN_LEN) state <= FCS;
        end
`endif
        FCS: begin
          tx_en   <= 1'b1;
          txd     <= fcs_byte;
          fcs_cnt <= fcs_cnt + 2'd1;
          if (fcs_cnt == 2'd3) begin
            ifg_cnt <= '0;
            state   <= IFG;
          end
        end
        IFG: begin
          tx_en <= 1'b0;
          txd   <= 8'h00;
          if (ifg_cnt == IFG_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_en <= 1'b0;
          txd   <= 8'h00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Self-checking bench for mac_tx_framer: directed and random frames against a
// byte-level reference model of the on-wire frame.
`timescale 1ns/1ps
module tb_mac_tx_framer;

  localparam int MIN_FRAME = 60;
  localparam int PRE_LEN   = 7;
  localparam int IFG       = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       underrun;
  logic       busy;

  always #5 clk = ~clk;

  mac_tx_framer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .txd      (txd),
    .tx_en    (tx_en),
    .tx_er    (tx_er),
    .underrun (underrun),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] src[$];
  bit         src_last[$];
  logic [7:0] exp_q[$];

  logic [7:0] cap_q[$];
  bit         cap_er[$];
  int         cap_lens[$];
  int         gap_lens[$];
  int         cur_len = 0;
  int         low_run = 0;
  bit         had_frame = 0;
  bit         prev_en = 0;
  int         irc = 0;
  int         urc = 0;

  // Wire monitor: records every tx_en byte, frame lengths and tx_en-low gaps.
  always @(negedge clk) begin
    if (in_ready) irc++;
    if (underrun) urc++;
    if (tx_en) begin
      if (!prev_en && had_frame) gap_lens.push_back(low_run);
      cap_q.push_back(txd);
      cap_er.push_back(tx_er);
      cur_len++;
    end else begin
      if (prev_en) begin
        cap_lens.push_back(cur_len);
        cur_len   = 0;
        had_frame = 1;
        low_run   = 0;
      end
      low_run++;
    end
    prev_en = tx_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_all();
    src.delete(); src_last.delete(); exp_q.delete();
    cap_q.delete(); cap_er.delete(); cap_lens.delete(); gap_lens.delete();
    cur_len = 0; low_run = 0; had_frame = 0; irc = 0; urc = 0;
  endtask

  // kind: 0 random bytes, 1 counting bytes, 2 ASCII "123..."
  task automatic add_frame(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      if (kind == 1)      src.push_back(8'(i));
      else if (kind == 2) src.push_back(8'(8'h31 + i));
      else                src.push_back(8'($urandom));
      src_last.push_back(i == n - 1);
    end
  endtask

  // Reference: wire image = preamble, SFD, body (padded when enabled), reflected CRC-32 LSB first.
  task automatic build_expected(input int first, input int n);
    logic [7:0]  body[$];
    logic [31:0] c;
    for (int i = 0; i < n; i++) body.push_back(src[first + i]);
`ifdef MAC_TX_PAD_EN
    while (body.size() < MIN_FRAME) body.push_back(8'h00);
`endif
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      c ^= {24'h0, body[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    repeat (PRE_LEN) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  // Streams src; stops with in_valid low after byte drop_at when drop_at >= 0.
  task automatic drive(input int drop_at, output bit to);
    int idx   = 0;
    int guard = 0;
    bit acc;
    to       = 0;
    in_valid = 1'b1;
    in_data  = src[0];
    in_last  = src_last[0];
    while (idx < src.size()) begin
      @(negedge clk);
      if (idx == drop_at) begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (idx == drop_at) break;
      if (acc) begin
        idx++;
        if (idx < src.size()) begin
          in_data = src[idx]; in_last = src_last[idx];
        end else begin
          in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        end
      end
      guard++;
      if (guard > 20000) begin
        to = 1;
        in_valid = 1'b0; in_last = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_frames(input string tag, input int nf);
    int g = 0;
    while (cap_lens.size() < nf && g < 6000) begin
      @(posedge clk); #2;
      g++;
    end
    check({tag, "_done"}, 32'(cap_lens.size() >= nf), 1);
  endtask

  task automatic compare_stream(input string tag, input int er_exp);
    int bad = 0;
    int ers = 0;
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) bad++;
    check({tag, "_bytes"}, bad, 0);
    foreach (cap_er[i]) if (cap_er[i]) ers++;
    check({tag, "_er"}, ers, er_exp);
  endtask

  task automatic check_ifg_then_idle(input string tag);
    int hi = 0;
    repeat (IFG) begin
      @(negedge clk);
      if (tx_en || tx_er) hi++;
    end
    check({tag, "_ifg_quiet"}, hi, 0);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_single(input string tag, input int n);
    bit to;
    build_expected(0, n);
    drive(-1, to);
    check({tag, "_drive"}, to, 0);
    wait_frames(tag, 1);
    compare_stream(tag, 0);
    check({tag, "_frame_len"}, cap_lens.size() > 0 ? cap_lens[0] : -1, exp_q.size());
    check({tag, "_ready_cycles"}, irc, n);
    check({tag, "_underrun"}, urc, 0);
    check_ifg_then_idle(tag);
  endtask

  initial begin
    bit to;
    int lens[3];
    int tot;
    int body_len;

    // Reset values, observed while reset is held and before any clock edge matters.
    #2 reset = 1'b1;
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_er", tx_er, 0);
    check("rst_txd", txd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    #19 reset = 1'b0;
    @(posedge clk); #1;

    // 60-byte counting frame: 72 tx_en cycles in either build.
    clear_all();
    add_frame(60, 1);
    run_single("f60", 60);
    check("f60_wire_cycles", cap_lens.size() > 0 ? cap_lens[0] : -1, 72);

    // "123456789": the well-known check value when sent unpadded.
    clear_all();
    add_frame(9, 2);
    run_single("ascii9", 9);
`ifndef MAC_TX_PAD_EN
    check("ascii9_cycles", cap_lens[0], 21);
    check("ascii9_fcs", {cap_q[20], cap_q[19], cap_q[18], cap_q[17]}, 32'hCBF4_3926);
`endif

    // Single byte 0xAA.
    clear_all();
    src.push_back(8'hAA); src_last.push_back(1'b1);
    run_single("one", 1);
`ifdef MAC_TX_PAD_EN
    check("one_cycles", cap_lens[0], 72);
`else
    check("one_cycles", cap_lens[0], 13);
`endif

    // Padding boundaries and random lengths, plus one frame past counter saturation.
    foreach (lens[i]) lens[i] = 0;
    for (int t = 0; t < 6; t++) begin
      int n;
      case (t)
        0: n = MIN_FRAME - 1;
        1: n = MIN_FRAME;
        2: n = MIN_FRAME + 1;
        3: n = 2050;
        default: n = $urandom_range(1, 100);
      endcase
      clear_all();
      add_frame(n, 0);
      run_single($sformatf("rnd%0d_n%0d", t, n), n);
    end

    // Underrun: 20-byte frame starved after 10 bytes.
    clear_all();
    add_frame(20, 0);
    repeat (PRE_LEN) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 10; i++) exp_q.push_back(src[i]);
    exp_q.push_back(8'h00);
    drive(10, to);
    check("urun_drive", to, 0);
    wait_frames("urun", 1);
    compare_stream("urun", 1);
    check("urun_er_last", cap_er.size() > 0 ? 32'(cap_er[cap_er.size() - 1]) : 32'hFFFF, 1);
    check("urun_pulses", urc, 1);
    check("urun_ready_cycles", irc, 11);
    check_ifg_then_idle("urun");

    // Back-to-back frames with in_valid held across the gap.
    clear_all();
    tot = 0;
    foreach (lens[i]) begin
      lens[i] = $urandom_range(1, 80);
      add_frame(lens[i], 0);
    end
    foreach (lens[i]) begin
      build_expected(tot, lens[i]);
      tot += lens[i];
    end
    drive(-1, to);
    check("b2b_drive", to, 0);
    wait_frames("b2b", 3);
    compare_stream("b2b", 0);
    check("b2b_gap_count", gap_lens.size(), 2);
    check("b2b_gap0", gap_lens.size() > 0 ? gap_lens[0] : -1, IFG + 1);
    check("b2b_gap1", gap_lens.size() > 1 ? gap_lens[1] : -1, IFG + 1);
    check("b2b_ready_cycles", irc, tot);
    check_ifg_then_idle("b2b");

    // Reset while FCS byte 2 is on the wire.
    clear_all();
    add_frame(30, 0);
    build_expected(0, 30);
`ifdef MAC_TX_PAD_EN
    body_len = MIN_FRAME;
`else
    body_len = 30;
`endif
    drive(-1, to);
    check("rstfcs_drive", to, 0);
    begin
      int g = 0;
      while (cap_q.size() < PRE_LEN + 1 + body_len + 2 && g < 2000) begin
        @(posedge clk); #2;
        g++;
      end
    end
    check("rstfcs_pre_en", tx_en, 1);
    check("rstfcs_pre_txd", txd, exp_q[PRE_LEN + 1 + body_len + 2]);
    reset = 1'b1;
    #1;
    check("rstfcs_tx_en", tx_en, 0);
    check("rstfcs_tx_er", tx_er, 0);
    check("rstfcs_txd", txd, 0);
    check("rstfcs_busy", busy, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #3;

    // Fresh frame right after reset release: no IFG is owed.
    clear_all();
    add_frame(5, 0);
    build_expected(0, 5);
    in_valid = 1'b1; in_data = src[0]; in_last = src_last[0];
    @(posedge clk); #1;
    check("post_rst_busy", busy, 1);
    check("post_rst_en0", tx_en, 0);
    @(posedge clk); #1;
    check("post_rst_en1", tx_en, 1);
    check("post_rst_txd", txd, 8'h55);
    drive(-1, to);
    check("post_rst_drive", to, 0);
    wait_frames("post_rst", 1);
    compare_stream("post_rst", 0);
    check_ifg_then_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
Ethernet MAC transmit framer that converts an upstream byte stream into one GMII-style transmit frame. It adds the 7-byte preamble and SFD, pads short payloads to the minimum frame length, and appends the 4-byte CRC-32 FCS. It then enforces the inter-frame gap. It sits between the TX packet buffer (upstream) and the GMII output registers (downstream).

Parameters:
MIN_FRAME, 60, minimum bytes before FCS (destination address through payload); shorter frames are zero-padded.
PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD.
IFG_BYTES, 12, idle cycles forced after each frame, including aborted ones.
CNT_W, 11, width of the byte counter; it saturates at all-ones.

Ports:
clk  in  1  transmit byte clock.
reset  in  1  asynchronous active-high reset.
in_data  in  8  frame byte, first byte = destination MAC byte 0.
in_valid  in  1  in_data is valid; once a frame starts, it must stay high every cycle until in_last.
in_last  in  1  marks the final byte of the frame; valid only with in_valid.
in_ready  out  1  combinational; high only in state DATA.
txd  out  8  registered GMII data.
tx_en  out  1  registered GMII enable.
tx_er  out  1  registered GMII error.
underrun  out  1  one-cycle pulse when a frame is aborted because of an underrun.
busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; txd=0x00; tx_en=0; tx_er=0; underrun=0; byte counter=0; CRC register=0xFFFFFFFF.
- Output timing: all outputs except in_ready are registered. The byte chosen in state S appears on txd/tx_en one cycle later.
- IDLE:
  - tx_en=0, in_ready=0.
  - If in_valid=1, go to PRE with preamble count=0. No byte is consumed.
  - First tx_en=1 is one cycle after the cycle in which in_valid is first seen.
- PRE: emit 0x55 PREAMBLE_LEN times, then go to SFD.
- SFD:
  - Emit 0xD5.
  - Set CRC=0xFFFFFFFF and byte counter=0.
  - Go to DATA.
- DATA: in_ready=1.
  - On in_valid=1: emit in_data, update the CRC with in_data, and increment the counter (saturating).
  - If in_last=1: go to PAD if counter+1 < MIN_FRAME, otherwise go to FCS.
  - If in_valid=0 (underrun):
    - Emit tx_er=1, tx_en=1, txd=0x00.
    - Pulse underrun.
    - Go to IFG. No FCS is sent.
- PAD: emit 0x00 with a CRC update and counter increment until the counter reaches MIN_FRAME, then go to FCS.
- FCS: four bytes, lowest-order first.
  - Each byte bit i = ~C[31-i].
  - After each byte the CRC register shifts left 8, filling with 0xFF.
  - After byte 3, go to IFG.
- IFG:
  - tx_en=0, txd=0x00.
  - Count IFG_BYTES cycles, then go to IDLE. in_valid is ignored during IFG.
- CRC update: IEEE 802.3 CRC-32, polynomial 0x04C11DB7, reflected byte input, one byte per cycle. Updates happen only on cycles flagged by the state machine; the CRC register holds otherwise.
- Frame length:
  - On-wire tx_en cycles = PREAMBLE_LEN + 1 + max(N, MIN_FRAME) + 4 for an N-byte frame.
  - Frames of 2^CNT_W-1 bytes or more: the counter saturates, with no truncation.
- Simultaneous events: in_last with in_valid in DATA at counter = MIN_FRAME-1 goes directly to FCS, not PAD.
- Reset mid-frame: everything returns to reset values immediately. tx_en drops asynchronously. No IFG is enforced after reset release.

Optional Feature:
MAC_TX_PAD_EN
- Defined: padding to MIN_FRAME as described above.
- Undefined:
  - The PAD state is removed; DATA with in_last goes straight to FCS.
  - Short frames are sent unpadded; MIN_FRAME is unused.
  - tx_en length = PREAMBLE_LEN + 1 + N + 4.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE, PRE, SFD, DATA, PAD, FCS, IFG);
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT=0xFFFFFFFF, CRC_POLY=0x04C11DB7.
- One sub-module, mac_tx_crc32, contains:
  - the 32-bit register;
  - inputs init, en, shift and data[7:0];
  - output fcs_byte[7:0].
- The framer owns the state machine, counters and output registers.

Test Plan:
1. 60-byte frame, bytes 0x00..0x3B:
   - tx_en high for exactly 72 cycles: 7×0x55, 0xD5, the 60 bytes, then 4 FCS bytes equal to the reference-model CRC.
   - Followed by 12 idle cycles.
2. 9-byte frame "123456789", MAC_TX_PAD_EN undefined:
   - FCS bytes are 0x26, 0x39, 0xF4, 0xCB (CRC 0xCBF43926).
   - tx_en high for 21 cycles.
3. 1-byte frame 0xAA with MAC_TX_PAD_EN:
   - Output is 0xAA followed by 59×0x00, then the FCS.
   - 72 tx_en cycles; in_ready high for exactly 1 cycle.
4. Underrun: 20-byte frame with in_valid dropped after byte 10:
   - Next cycle has tx_er=1 and a single underrun pulse, with no FCS.
   - 12 IFG cycles follow; busy=0 afterwards.
5. Back-to-back frames with in_valid held high:
   - Exactly 12 cycles with tx_en=0 between frames, plus one IDLE cycle.
   - in_ready stays low during IFG.
6. Assert reset during FCS byte 2:
   - tx_en/tx_er/txd go to 0 without waiting for a clock edge.
   - After release, a new frame starts one cycle after in_valid.
